vga_dac_host_ctrl: RTL and testbench

VGA_DAC_HOST_CTRL -- requirements
Module: vga_dac_host_ctrl

---
 rtl/vga_dac_host_ctrl.sv | 147 ++++++++++++++
 tb/tb_vga_dac_host_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dac_host_ctrl.sv
// VGA DAC host-side port controller (3C6..3C9): index/cycle sequencing and DAC strobes.
// Define VGA_DAC_PEL_MASK_EN to make 3C6 a read/write PEL mask; otherwise it reads 8'hFF.
module vga_dac_host_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_stb,
    input  logic       io_we,
    input  logic [1:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_ack,
    output logic       dac_we,
    output logic [1:0] dac_write_data_cycle,
    output logic [7:0] dac_write_data_register,
    output logic [3:0] dac_write_data,
    output logic [1:0] dac_read_data_cycle,
    output logic [7:0] dac_read_data_register,
    input  logic [3:0] dac_read_data,
    output logic [7:0] pel_mask
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    localparam logic [1:0] A_PEL  = 2'd0;
    localparam logic [1:0] A_RIDX = 2'd1;
    localparam logic [1:0] A_WIDX = 2'd2;
    localparam logic [1:0] A_DATA = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_rdata;
    logic       r_dac_we;
    logic [3:0] r_dac_wdata;
    logic [7:0] r_wr_idx;
    logic [1:0] r_wr_cyc;
    logic [7:0] r_rd_idx;
    logic [1:0] r_rd_cyc;
    logic [1:0] r_dac_state;
    logic [7:0] w_pel_mask;
    logic       w_accept;

    assign w_accept = (r_state == ST_IDLE) && io_stb;

`ifdef VGA_DAC_PEL_MASK_EN
    logic [7:0] r_pel_mask;

    always_ff @(posedge clk) begin
        if (!rst)
            r_pel_mask <= 8'hFF;
        else if (w_accept && io_we && (io_addr == A_PEL))
            r_pel_mask <= io_wdata;
    end

    assign w_pel_mask = r_pel_mask;
`else
    assign w_pel_mask = 8'hFF;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rdata     <= 8'h00;
            r_dac_we    <= 1'b0;
            r_dac_wdata <= 4'h0;
            r_wr_idx    <= 8'h00;
            r_wr_cyc    <= 2'd0;
            r_rd_idx    <= 8'h00;
            r_rd_cyc    <= 2'd0;
            r_dac_state <= 2'b00;
        end else begin
            r_dac_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_stb) begin
                        if (io_we) begin
                            r_rdata <= 8'h00;
                            r_state <= ST_ACK;
                            case (io_addr)
                                A_PEL: ;
                                A_RIDX: begin
                                    r_rd_idx    <= io_wdata;
                                    r_rd_cyc    <= 2'd0;
                                    r_dac_state <= 2'b11;
                                end
                                A_WIDX: begin
                                    r_wr_idx    <= io_wdata;
                                    r_wr_cyc    <= 2'd0;
                                    r_dac_state <= 2'b00;
                                end
                                default: begin
                                    r_dac_we    <= 1'b1;
                                    r_dac_wdata <= io_wdata[5:2];
                                end
                            endcase
                        end else if (io_addr == A_DATA) begin
                            r_state <= ST_RD_WAIT;
                        end else begin
                            r_state <= ST_ACK;
                            case (io_addr)
                                A_PEL:   r_rdata <= w_pel_mask;
                                A_RIDX:  r_rdata <= {6'b0, r_dac_state};
                                default: r_rdata <= r_wr_idx;
                            endcase
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // The DAC has had the full acceptance cycle to present the addressed component.
                    r_rdata <= {2'b00, dac_read_data, 2'b00};
                    if (r_rd_cyc == 2'd2) begin
                        r_rd_cyc <= 2'd0;
                        r_rd_idx <= r_rd_idx + 8'd1;
                    end else begin
                        r_rd_cyc <= r_rd_cyc + 2'd1;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    // Advance only after the strobe so the DAC sees the pre-increment index/cycle.
                    if (r_dac_we) begin
                        if (r_wr_cyc == 2'd2) begin
                            r_wr_cyc <= 2'd0;
                            r_wr_idx <= r_wr_idx + 8'd1;
                        end else begin
                            r_wr_cyc <= r_wr_cyc + 2'd1;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_ack                  = (r_state == ST_ACK);
    assign io_rdata                = r_rdata;
    assign dac_we                  = r_dac_we;
    assign dac_write_data          = r_dac_wdata;
    assign dac_write_data_cycle    = r_wr_cyc;
    assign dac_write_data_register = r_wr_idx;
    assign dac_read_data_cycle     = r_rd_cyc;
    assign dac_read_data_register  = r_rd_idx;
    assign pel_mask                = w_pel_mask;

endmodule

// File: tb/tb_vga_dac_host_ctrl.sv
// Directed bench for vga_dac_host_ctrl: register access, DAC strobe sequencing, reset abort.
// Honors VGA_DAC_PEL_MASK_EN the same way as the design.
module tb_vga_dac_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_stb;
    logic       io_we;
    logic [1:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_ack;
    logic       dac_we;
    logic [1:0] dac_write_data_cycle;
    logic [7:0] dac_write_data_register;
    logic [3:0] dac_write_data;
    logic [1:0] dac_read_data_cycle;
    logic [7:0] dac_read_data_register;
    logic [3:0] dac_read_data;
    logic [7:0] pel_mask;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] idx;
        logic [1:0] cyc;
        logic [3:0] data;
    } we_t;

    we_t we_log[$];

    vga_dac_host_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .io_stb                  (io_stb),
        .io_we                   (io_we),
        .io_addr                 (io_addr),
        .io_wdata                (io_wdata),
        .io_rdata                (io_rdata),
        .io_ack                  (io_ack),
        .dac_we                  (dac_we),
        .dac_write_data_cycle    (dac_write_data_cycle),
        .dac_write_data_register (dac_write_data_register),
        .dac_write_data          (dac_write_data),
        .dac_read_data_cycle     (dac_read_data_cycle),
        .dac_read_data_register  (dac_read_data_register),
        .dac_read_data           (dac_read_data),
        .pel_mask                (pel_mask)
    );

    always #5 clk = ~clk;

    // Palette model: component value = index[3:0] + 4 + cycle, one clock after presentation.
    always @(posedge clk)
        dac_read_data <= dac_read_data_register[3:0] + 4'd4 + {2'b00, dac_read_data_cycle};

    always @(negedge clk)
        if (dac_we)
            we_log.push_back('{dac_write_data_register, dac_write_data_cycle, dac_write_data});

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int lat);
        io_stb   = 1'b1;
        io_we    = we;
        io_addr  = addr;
        io_wdata = wd;
        lat      = 0;
        rd       = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (io_ack) begin
                lat = i;
                rd  = io_rdata;
                break;
            end
        end
        io_stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        int         lat;
        int         ack_seen;
        int         we_before;

        rst      = 1'b0;
        io_stb   = 1'b0;
        io_we    = 1'b0;
        io_addr  = 2'd0;
        io_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",    8'(io_ack), 8'h00);
        check("rst_rdata",  io_rdata, 8'h00);
        check("rst_dac_we", 8'(dac_we), 8'h00);
        check("rst_wr_idx", dac_write_data_register, 8'h00);
        check("rst_wr_cyc", 8'(dac_write_data_cycle), 8'h00);
        check("rst_rd_idx", dac_read_data_register, 8'h00);
        check("rst_rd_cyc", 8'(dac_read_data_cycle), 8'h00);
        check("rst_pel",    pel_mask, 8'hFF);
        @(posedge clk);
        #1 rst = 1'b1;

        xfer(1'b0, 2'd1, 8'h00, rd, lat);
        check("rst_dac_state", rd, 8'h00);

        // Write sequence at index 0x10.
        xfer(1'b1, 2'd2, 8'h10, rd, lat);
        check("w3c8_lat",   8'(lat), 8'd1);
        check("w3c8_rdata", rd, 8'h00);
        xfer(1'b1, 2'd3, 8'h3F, rd, lat);
        check("w3c9_lat", 8'(lat), 8'd1);
        xfer(1'b1, 2'd3, 8'h00, rd, lat);
        xfer(1'b1, 2'd3, 8'h2A, rd, lat);
        check("we_cnt3", 8'(we_log.size()), 8'd3);
        if (we_log.size() >= 3) begin
            check("we0_idx", we_log[0].idx, 8'h10);
            check("we0_cyc", 8'(we_log[0].cyc), 8'd0);
            check("we0_dat", 8'(we_log[0].data), 8'h0F);
            check("we1_idx", we_log[1].idx, 8'h10);
            check("we1_cyc", 8'(we_log[1].cyc), 8'd1);
            check("we1_dat", 8'(we_log[1].data), 8'h00);
            check("we2_idx", we_log[2].idx, 8'h10);
            check("we2_cyc", 8'(we_log[2].cyc), 8'd2);
            check("we2_dat", 8'(we_log[2].data), 8'h0A);
        end
        xfer(1'b0, 2'd2, 8'h00, rd, lat);
        check("r3c8_after3", rd, 8'h11);
        check("wr_cyc_wrap", 8'(dac_write_data_cycle), 8'd0);

        // Index wrap 0xFF -> 0x00.
        xfer(1'b1, 2'd2, 8'hFF, rd, lat);
        xfer(1'b1, 2'd3, 8'h04, rd, lat);
        xfer(1'b1, 2'd3, 8'h08, rd, lat);
        xfer(1'b1, 2'd3, 8'h0C, rd, lat);
        xfer(1'b1, 2'd3, 8'h10, rd, lat);
        check("we_cnt7", 8'(we_log.size()), 8'd7);
        if (we_log.size() >= 7) begin
            check("we5_idx", we_log[5].idx, 8'hFF);
            check("we5_cyc", 8'(we_log[5].cyc), 8'd2);
            check("we6_idx", we_log[6].idx, 8'h00);
            check("we6_cyc", 8'(we_log[6].cyc), 8'd0);
            check("we6_dat", 8'(we_log[6].data), 8'h04);
        end

        // Read sequence from index 0x05.
        xfer(1'b1, 2'd1, 8'h05, rd, lat);
        check("w3c7_rd_idx", dac_read_data_register, 8'h05);
        xfer(1'b0, 2'd3, 8'h00, rd, lat);
        check("r3c9_lat",   8'(lat), 8'd2);
        check("r3c9_0",     rd, 8'h24);
        xfer(1'b0, 2'd1, 8'h00, rd, lat);
        check("r3c7_state", rd, 8'h03);
        xfer(1'b0, 2'd3, 8'h00, rd, lat);
        check("r3c9_1", rd, 8'h28);
        xfer(1'b0, 2'd3, 8'h00, rd, lat);
        check("r3c9_2", rd, 8'h2C);
        check("rd_idx_adv", dac_read_data_register, 8'h06);
        check("rd_cyc_wrap", 8'(dac_read_data_cycle), 8'd0);

        xfer(1'b1, 2'd2, 8'h20, rd, lat);
        xfer(1'b0, 2'd1, 8'h00, rd, lat);
        check("r3c7_after_w3c8", rd, 8'h00);
        check("we_cnt_no_spurious", 8'(we_log.size()), 8'd7);

        // PEL mask register.
        xfer(1'b1, 2'd0, 8'h0F, rd, lat);
        check("w3c6_lat", 8'(lat), 8'd1);
        xfer(1'b0, 2'd0, 8'h00, rd, lat);
`ifdef VGA_DAC_PEL_MASK_EN
        check("r3c6", rd, 8'h0F);
        check("pel_mask_out", pel_mask, 8'h0F);
`else
        check("r3c6", rd, 8'hFF);
        check("pel_mask_out", pel_mask, 8'hFF);
`endif

        // Reset while in RD_WAIT aborts the read.
        xfer(1'b1, 2'd1, 8'h00, rd, lat);
        we_before = we_log.size();
        io_stb  = 1'b1;
        io_we   = 1'b0;
        io_addr = 2'd3;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        io_stb = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (io_ack) ack_seen++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        if (io_ack) ack_seen++;
        check("abort_no_ack", 8'(ack_seen), 8'd0);
        check("abort_rd_idx", dac_read_data_register, 8'h00);
        check("abort_rd_cyc", 8'(dac_read_data_cycle), 8'd0);
        check("abort_pel",    pel_mask, 8'hFF);
        check("abort_no_we",  8'(we_log.size() - we_before), 8'd0);
        @(posedge clk);
        #1;
        xfer(1'b0, 2'd2, 8'h00, rd, lat);
        check("post_rst_r3c8", rd, 8'h00);
        check("post_rst_lat",  8'(lat), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
